fht_input_loader: RTL
=====================

FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

Interface
REQ-001 SHALL have parameter A_BIT, default 9: bank address width; block size N = 4*2^A_BIT (2048 points).
REQ-002 SHALL have parameter D_BIT, default 16: sample width.
REQ-003 SHALL have port iCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port iRESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iVALID  input  1  upstream sample valid.
REQ-006 SHALL have port iDATA  input  D_BIT  upstream sample.
REQ-007 SHALL have port oREADY  output  1  loader accepts a sample this cycle.
REQ-008 SHALL have port iCLEAR  input  1  synchronous abort, restarts block loading.
REQ-009 SHALL have port iFHT_RDY  input  1  RDY from fht_control (high = transform finished/idle).
REQ-010 SHALL have port oWR_ADDR  output  A_BIT  bank RAM write address.
REQ-011 SHALL have port oWR_DATA  output  D_BIT  bank RAM write data.
REQ-012 SHALL have port oWE  output  4  one-hot bank write enable, bit k = bank k.
REQ-013 SHALL have port oSTART  output  1  one-cycle start pulse to fht_control iSTART.
REQ-014 SHALL have port oCNT  output  A_BIT+2  samples accepted in current block.
REQ-015 SHALL have port oOVF  output  1  sticky: iVALID seen while oREADY low in WAIT.

Function
REQ-016 SHALL transfer a sample on a cycle where iVALID=1 and oREADY=1; no other cycle transfers.
REQ-017 SHALL implement FSM states LOAD, FLUSH, START, WAIT; oREADY=1 only in LOAD, decoded from the state register.
REQ-018 SHALL, on accepting sample index i (0..N-1), form r = bit-reverse of i over A_BIT+2 bits; bank = r[A_BIT+1:A_BIT], address = r[A_BIT-1:0].
REQ-019 SHALL register the write: transfer at cycle t gives oWE one-hot, oWR_ADDR, oWR_DATA=iDATA at cycle t+1, for exactly one cycle; oWE=0 otherwise.
REQ-020 SHALL increment oCNT per transfer; on transfer of index N-1 go LOAD->FLUSH and reset oCNT to 0.
REQ-021 SHALL, in FLUSH (final write issued), go to START next cycle; in START drive oSTART=1 for one cycle, then go to WAIT.
REQ-022 SHALL register iFHT_RDY; in WAIT return to LOAD on its rising edge (current 1, previous 0); a level already high on WAIT entry SHALL NOT release WAIT.
REQ-023 SHALL set oOVF when iVALID=1 in FLUSH, START or WAIT; oOVF holds until iCLEAR or reset.
REQ-024 SHALL, on iCLEAR=1, go to LOAD next cycle, with oCNT=0, oOVF=0, oWE=0, oSTART=0; a transfer in that cycle is discarded; iCLEAR overrides all transitions.
REQ-025 SHALL keep oCNT and state unchanged in LOAD while iVALID=0 (gaps allowed).

Reset
REQ-026 SHALL, while iRESET=0, force state LOAD, oCNT=0, oWE=0, oWR_ADDR=0, oWR_DATA=0, oSTART=0, oOVF=0, registered iFHT_RDY=1; oREADY=1 after release.
REQ-027 SHALL, when reset asserts mid-block, discard the partial block; the next block starts at index 0.

Verification
REQ-028 Reset then samples i=0..4 with iVALID=1 -> oWE/oWR_ADDR: 0001/0, 0100/0, 0010/0, 1000/0, 0001/256, each one cycle after transfer.
REQ-029 Stream 2048 samples back-to-back, last at cycle t -> oREADY=0 from t+1, last write at t+1, oSTART=1 only at t+2, oCNT=0.
REQ-030 In WAIT hold iFHT_RDY=1 from entry for 50 cycles -> stays WAIT; drive 0 then 1 -> oREADY=1 two cycles after the rising edge.
REQ-031 Drive iVALID=1 during WAIT -> oOVF=1 next cycle and held; oWE stays 0; iCLEAR -> oOVF=0, oCNT=0, oREADY=1.
REQ-032 Load 700 samples with random iVALID gaps, then iRESET=0 -> all outputs at reset values; next sample writes bank 0 address 0.
REQ-033 Full 2048 load with random gaps -> every (bank,address) pair written exactly once, data matching bit-reversed index; scoreboarded.

Source files
------------

// File: rtl/fht_input_loader.sv
// Streams samples into four FHT bank RAMs in bit-reversed order, then pulses
// the transform start and waits for the transform to finish before loading again.
module fht_input_loader #(
  parameter int A_BIT = 9,
  parameter int D_BIT = 16
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iVALID,
  input  logic [D_BIT-1:0]   iDATA,
  output logic               oREADY,
  input  logic               iCLEAR,
  input  logic               iFHT_RDY,
  output logic [A_BIT-1:0]   oWR_ADDR,
  output logic [D_BIT-1:0]   oWR_DATA,
  output logic [3:0]         oWE,
  output logic               oSTART,
  output logic [A_BIT+1:0]   oCNT,
  output logic               oOVF
);

  // state | meaning
  // LOAD  | accepting samples, writing banks
  // FLUSH | final bank write on the bus
  // START | oSTART pulse to fht_control
  // WAIT  | transform running; wait for RDY rising edge
  typedef enum logic [1:0] {LOAD, FLUSH, START, WAIT} state_t;

  localparam int C_BIT = A_BIT + 2;
  localparam logic [C_BIT-1:0] CNT_ONE = 1;

  state_t           state;
  logic             rdy_q;
  logic             rdy_prev;
  logic             xfer;
  logic [C_BIT-1:0] rev;
  logic [1:0]       bank;

  assign oREADY = (state == LOAD);
  assign xfer   = iVALID & oREADY;

  always_comb begin
    rev = '0;
    for (int k = 0; k < C_BIT; k++) rev[k] = oCNT[C_BIT-1-k];
  end

  assign bank = rev[C_BIT-1:A_BIT];

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state    <= LOAD;
      oCNT     <= '0;
      oWE      <= '0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
      oSTART   <= 1'b0;
      oOVF     <= 1'b0;
      rdy_q    <= 1'b1;
      rdy_prev <= 1'b1;
    end else begin
      rdy_q    <= iFHT_RDY;
      rdy_prev <= rdy_q;
      oWE      <= '0;
      oSTART   <= 1'b0;
      if (iCLEAR) begin
        state <= LOAD;
        oCNT  <= '0;
        oOVF  <= 1'b0;
      end else begin
        if (iVALID && state != LOAD) oOVF <= 1'b1;
        case (state)
          LOAD: begin
            if (xfer) begin
              oWE      <= 4'b0001 << bank;
              oWR_ADDR <= rev[A_BIT-1:0];
              oWR_DATA <= iDATA;
              // counter wraps to zero on the last index of the block
              oCNT     <= oCNT + CNT_ONE;
              if (&oCNT) state <= FLUSH;
            end
          end
          FLUSH: begin
            state  <= START;
            oSTART <= 1'b1;
          end
          START: state <= WAIT;
          WAIT: begin
            // only a fresh rising edge releases; a stale high level does not
            if (rdy_q && !rdy_prev) state <= LOAD;
          end
          default: state <= LOAD;
        endcase
      end
    end
  end

endmodule
